// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_if
// Description : Operand/result bundle between a requester and serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Sum;
   logic             Carry;
   logic             overflow;

   modport master (
      output start, sub, a, b,
      input  busy, done, Sum, Carry, overflow
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, Sum, Carry, overflow
   );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder/subtractor, one bit per clock, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_c;
   logic [CW-1:0]    r_cnt;

   logic             w_s;
   logic             w_cout;
   logic [WIDTH-1:0] w_res_next;

   assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
   assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

   // Result fills from the MSB end so the LSB lands at bit 0 after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_res_one
         assign w_res_next = w_s;
      end else begin : g_res_multi
         assign w_res_next = {w_s, r_res[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_res        <= '0;
         r_c          <= 1'b0;
         r_cnt        <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.Sum      <= '0;
         bus.Carry    <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_res <= w_res_next;
               r_c   <= w_cout;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == c_last_bit) begin
                  // r_c still holds the carry into the MSB at this point.
                  bus.Sum      <= w_res_next;
                  bus.Carry    <= w_cout;
                  bus.overflow <= r_c ^ w_cout;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  r_state      <= DONE;
               end
            end
            default: begin
               // IDLE and DONE accept a new request identically.
               bus.done <= 1'b0;
               if (bus.start) begin
                  r_a      <= bus.a;
                  r_b      <= bus.b ^ {WIDTH{bus.sub}};
                  r_c      <= bus.sub;
                  r_cnt    <= '0;
                  bus.busy <= 1'b1;
                  r_state  <= RUN;
               end else begin
                  bus.busy <= 1'b0;
                  r_state  <= IDLE;
               end
            end
         endcase
      end
   end
endmodule
`default_nettype wire
